load_store_aligner: RTL and testbench
=====================================

LOAD_STORE_ALIGNER -- requirements
Module: load_store_aligner

Interface
REQ-001 Parameter DATA_BITS, default 32, memory/data width; legal values 32 and 64.
REQ-002 Parameter ADDR_BITS, default 32, byte-address width.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_valid  input  1  pipeline request valid.
REQ-006 o_ready  output  1  aligner can accept a request.
REQ-007 i_is_store  input  1  1 = store, 0 = load.
REQ-008 i_op  input  3  access type: 000 B, 001 H, 011 W, 010 D (DATA_BITS=64 only), 100 BU, 101 HU; stores ignore bit 2.
REQ-009 i_addr  input  ADDR_BITS  byte address.
REQ-010 i_wdata  input  DATA_BITS  store data, right-justified.
REQ-011 o_mem_en  output  1  memory access strobe.
REQ-012 o_mem_we  output  DATA_BITS/8  per-byte write enables.
REQ-013 o_mem_addr  output  ADDR_BITS  aligned address; low log2(DATA_BITS/8) bits zero.
REQ-014 o_mem_wdata  output  DATA_BITS  lane-replicated store data.
REQ-015 i_mem_rdata  input  DATA_BITS  memory read data, valid with i_mem_ack.
REQ-016 i_mem_ack  input  1  memory completion, one-cycle pulse.
REQ-017 o_valid  output  1  response valid.
REQ-018 i_ready  input  1  consumer accepts response.
REQ-019 o_rdata  output  DATA_BITS  extended load result; 0 for stores.
REQ-020 o_misaligned  output  1  response flags misaligned/reserved access.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; o_ready = 1 only in IDLE.
REQ-022 IDLE: i_valid=1 latches request and moves to ACCESS; o_mem_en asserts next cycle (1-cycle issue latency).
REQ-023 ACCESS: o_mem_en, o_mem_addr, o_mem_we and o_mem_wdata held stable until i_mem_ack; ack moves to RESP and registers the read data.
REQ-024 RESP: o_valid=1 with o_rdata stable until i_ready=1, then IDLE; new request accepted no earlier than the following cycle.
REQ-025 Lane offset = i_addr[log2(DATA_BITS/8)-1:0]; load selects byte/half/word at offset*8.
REQ-026 B/H/W sign-extend from the selected field's MSB to DATA_BITS; BU/HU zero-extend; D passes through.
REQ-027 Store: o_mem_wdata = low field of i_wdata replicated across all lanes; o_mem_we sets exactly the bytes of the addressed field.
REQ-028 Loads drive o_mem_we = 0.
REQ-029 Reserved op (010 at DATA_BITS=32, 11x): no memory access; ACCESS skipped; RESP with o_rdata=0, o_misaligned=1.
REQ-030 i_mem_ack outside ACCESS is ignored.
REQ-031 i_valid while not in IDLE is ignored; the requester holds it.

Reset
REQ-032 On i_rst: state IDLE; o_ready=1; o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_valid=0, o_rdata=0, o_misaligned=0.
REQ-033 Reset mid-ACCESS or mid-RESP abandons the transaction; o_mem_en and o_valid are low from the first cycle after the reset edge.

Configuration
REQ-034 Macro LS_MISALIGN_TRAP_EN: when defined, an access whose offset is not a multiple of its size skips memory and responds in RESP with o_rdata=0, o_misaligned=1.
REQ-035 Without LS_MISALIGN_TRAP_EN, offset bits below the access size are forced to zero (access rounded down); o_misaligned is tied 0 except for reserved ops.

Verification (DATA_BITS=32)
REQ-036 LB at 0x101, rdata 0x5787C949 -> o_mem_addr 0x100, o_rdata 0xFFFFFFC9, o_misaligned 0.
REQ-037 HU load at 0x102, rdata 0x8E870E49 -> o_rdata 0x00008E87; H at same -> 0xFFFF8E87.
REQ-038 Store H at 0x006, i_wdata 0x0000ABCD -> o_mem_addr 0x004, o_mem_we 4'b1100, o_mem_wdata 0xABCDABCD, o_rdata 0.
REQ-039 W load at 0x002: with macro -> no o_mem_en, o_misaligned 1, o_rdata 0; without -> o_mem_addr 0x000, full word returned.
REQ-040 Ack delayed 4 cycles, then i_ready low 3 cycles -> o_mem_en held 4 cycles, o_valid/o_rdata stable 3 cycles, o_ready 0 throughout.
REQ-041 i_rst asserted during ACCESS, then ack pulse -> all outputs at reset values, no o_valid produced.

Source files
------------

// File: rtl/load_store_aligner.sv
// Load/store aligner: lane-aligns memory requests and sign/zero-extends load data.
// Optional macro LS_MISALIGN_TRAP_EN traps unaligned accesses instead of rounding them down.
module load_store_aligner #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_is_store,
    input  logic [2:0]             i_op,
    input  logic [ADDR_BITS-1:0]   i_addr,
    input  logic [DATA_BITS-1:0]   i_wdata,
    output logic                   o_mem_en,
    output logic [DATA_BITS/8-1:0] o_mem_we,
    output logic [ADDR_BITS-1:0]   o_mem_addr,
    output logic [DATA_BITS-1:0]   o_mem_wdata,
    input  logic [DATA_BITS-1:0]   i_mem_rdata,
    input  logic                   i_mem_ack,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATA_BITS-1:0]   o_rdata,
    output logic                   o_misaligned
);

    localparam int LANES    = DATA_BITS / 8;
    localparam int OFF_BITS = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state_reg;
    logic                   mem_en_reg;
    logic [LANES-1:0]       mem_we_reg;
    logic [ADDR_BITS-1:0]   mem_addr_reg;
    logic [DATA_BITS-1:0]   mem_wdata_reg;
    logic                   valid_reg;
    logic [DATA_BITS-1:0]   rdata_reg;
    logic                   misaligned_reg;
    logic [2:0]             op_reg;
    logic [OFF_BITS-1:0]    off_reg;
    logic                   is_store_reg;

    // Request decode, evaluated on the incoming request in IDLE
    logic [2:0]             eff_op;
    logic [1:0]             size_log;
    logic                   reserved;
    logic [OFF_BITS-1:0]    off_raw;
    logic [OFF_BITS-1:0]    size_mask;
    logic [OFF_BITS-1:0]    off_eff;
    logic                   trap;
    logic [LANES-1:0]       lane_we;
    logic [DATA_BITS-1:0]   wdata_rep;

    assign eff_op  = i_is_store ? {1'b0, i_op[1:0]} : i_op;
    assign off_raw = i_addr[OFF_BITS-1:0];

    always_comb begin
        reserved = 1'b0;
        size_log = 2'd0;
        case (eff_op)
            3'b000, 3'b100: size_log = 2'd0;
            3'b001, 3'b101: size_log = 2'd1;
            3'b011:         size_log = 2'd2;
            3'b010: begin
                if (DATA_BITS == 64) size_log = 2'd3;
                else                 reserved = 1'b1;
            end
            default:        reserved = 1'b1;
        endcase
    end

    always_comb begin
        case (size_log)
            2'd0:    size_mask = '0;
            2'd1:    size_mask = OFF_BITS'(1);
            2'd2:    size_mask = OFF_BITS'(3);
            default: size_mask = OFF_BITS'(7);
        endcase
    end

    assign off_eff = off_raw & ~size_mask;

`ifdef LS_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = |(off_raw & size_mask);
    assign trap     = reserved | misalign;
`else
    assign trap     = reserved;
`endif

    // Per-lane write enable and replicated store data
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [OFF_BITS:0] LANE = (OFF_BITS+1)'(gi);
            logic [OFF_BITS:0] rel;
            // rel is negative (MSB set) when this lane sits below the field start
            assign rel         = LANE - {1'b0, off_eff};
            assign lane_we[gi] = i_is_store && !rel[OFF_BITS] &&
                                 (rel[OFF_BITS-1:0] <= size_mask);
            assign wdata_rep[gi*8 +: 8] =
                (size_log == 2'd0) ? i_wdata[7:0] :
                (size_log == 2'd1) ? i_wdata[(gi % 2)*8 +: 8] :
                (size_log == 2'd2) ? i_wdata[(gi % 4)*8 +: 8] :
                                     i_wdata[gi*8 +: 8];
        end
    endgenerate

    // Load extraction from the latched lane offset and access type
    logic [DATA_BITS-1:0] rd_shift;
    logic [DATA_BITS-1:0] word_ext;
    logic [DATA_BITS-1:0] load_ext;

    assign rd_shift = i_mem_rdata >> {off_reg, 3'b000};

    generate
        if (DATA_BITS == 64) begin : g_word64
            assign word_ext = {{(DATA_BITS-32){rd_shift[31]}}, rd_shift[31:0]};
        end else begin : g_word32
            assign word_ext = rd_shift;
        end
    endgenerate

    always_comb begin
        load_ext = '0;
        case (op_reg)
            3'b000:  load_ext = {{(DATA_BITS-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_ext = {{(DATA_BITS-8){1'b0}}, rd_shift[7:0]};
            3'b001:  load_ext = {{(DATA_BITS-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_ext = {{(DATA_BITS-16){1'b0}}, rd_shift[15:0]};
            3'b011:  load_ext = word_ext;
            3'b010:  load_ext = rd_shift;
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            valid_reg      <= 1'b0;
            rdata_reg      <= '0;
            misaligned_reg <= 1'b0;
            op_reg         <= '0;
            off_reg        <= '0;
            is_store_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        op_reg       <= eff_op;
                        off_reg      <= off_eff;
                        is_store_reg <= i_is_store;
                        if (trap) begin
                            state_reg      <= RESP;
                            valid_reg      <= 1'b1;
                            rdata_reg      <= '0;
                            misaligned_reg <= 1'b1;
                        end else begin
                            state_reg      <= ACCESS;
                            mem_en_reg     <= 1'b1;
                            mem_addr_reg   <= {i_addr[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
                            mem_we_reg     <= lane_we;
                            mem_wdata_reg  <= i_is_store ? wdata_rep : '0;
                            misaligned_reg <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (i_mem_ack) begin
                        state_reg  <= RESP;
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= '0;
                        valid_reg  <= 1'b1;
                        rdata_reg  <= is_store_reg ? '0 : load_ext;
                    end
                end
                RESP: begin
                    if (i_ready) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_ready      = (state_reg == IDLE);
    assign o_mem_en     = mem_en_reg;
    assign o_mem_we     = mem_we_reg;
    assign o_mem_addr   = mem_addr_reg;
    assign o_mem_wdata  = mem_wdata_reg;
    assign o_valid      = valid_reg;
    assign o_rdata      = rdata_reg;
    assign o_misaligned = misaligned_reg;

endmodule

// File: tb/tb_load_store_aligner.sv
// Directed table-driven bench for load_store_aligner at DATA_BITS=32;
// expectations follow LS_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_store_aligner;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_is_store;
    logic [2:0]  i_op;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_mem_en;
    logic [3:0]  o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rdata;
    logic        o_misaligned;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    load_store_aligner #(.DATA_BITS(32), .ADDR_BITS(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_is_store  (i_is_store),
        .i_op        (i_op),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_rdata     (o_rdata),
        .o_misaligned(o_misaligned)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  64'(o_ready), 64'd1);
        check({tag, "_en"},     64'(o_mem_en), 64'd0);
        check({tag, "_we"},     64'(o_mem_we), 64'd0);
        check({tag, "_addr"},   64'(o_mem_addr), 64'd0);
        check({tag, "_wdata"},  64'(o_mem_wdata), 64'd0);
        check({tag, "_valid"},  64'(o_valid), 64'd0);
        check({tag, "_rdata"},  64'(o_rdata), 64'd0);
        check({tag, "_mis"},    64'(o_misaligned), 64'd0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          rdy_dly;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input int idx, input vec_t v);
        int          en_cycles = 0;
        int          iter = 0;
        logic        busy_bad = 1'b0;
        logic        mem_unstable = 1'b0;
        logic        resp_bad = 1'b0;
        logic [3:0]  cap_we = '0;
        logic [31:0] cap_addr = '0;
        logic [31:0] cap_wdata = '0;
        logic [31:0] cap_rdata;
        logic        cap_mis;

        check("idle_ready", 64'(o_ready), 64'd1);
        i_is_store = v.st;
        i_op       = v.op;
        i_addr     = v.addr;
        i_wdata    = v.wdata;
        i_valid    = 1'b1;
        @(negedge i_clk);
        // requester keeps i_valid high; scrambled fields must be ignored while busy
        i_addr  = 32'hFFFF_FFFF;
        i_op    = 3'b011;
        i_wdata = 32'h1357_9BDF;
        if (v.exp_en) check("issue_latency_en", 64'(o_mem_en), 64'd1);
        else          check("issue_latency_resp", 64'(o_valid), 64'd1);

        while (!o_valid && iter < 40) begin
            if (o_ready) busy_bad = 1'b1;
            if (o_mem_en) begin
                en_cycles++;
                if (en_cycles == 1) begin
                    cap_we = o_mem_we; cap_addr = o_mem_addr; cap_wdata = o_mem_wdata;
                end else if (o_mem_we !== cap_we || o_mem_addr !== cap_addr ||
                             o_mem_wdata !== cap_wdata) begin
                    mem_unstable = 1'b1;
                end
                if (en_cycles == v.ack_dly) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = v.rdata;
                end
            end
            @(negedge i_clk);
            i_mem_ack   = 1'b0;
            i_mem_rdata = $urandom;
            iter++;
        end
        check("resp_timeout", 64'(o_valid), 64'd1);
        check("mem_en_cycles", 64'(en_cycles), v.exp_en ? 64'(v.ack_dly) : 64'd0);
        check("mem_stable", 64'(mem_unstable), 64'd0);
        if (v.exp_en) begin
            check("mem_addr", 64'(cap_addr), 64'(v.exp_addr));
            check("mem_we", 64'(cap_we), 64'(v.exp_we));
            if (v.st) check("mem_wdata", 64'(cap_wdata), 64'(v.exp_wdata));
        end

        cap_rdata = o_rdata;
        cap_mis   = o_misaligned;
        check("rdata", 64'(cap_rdata), 64'(v.exp_rdata));
        check("misaligned", 64'(cap_mis), 64'(v.exp_mis));
        for (int k = 0; k < v.rdy_dly; k++) begin
            if (!o_valid || o_rdata !== cap_rdata || o_misaligned !== cap_mis) resp_bad = 1'b1;
            if (o_ready) busy_bad = 1'b1;
            @(negedge i_clk);
        end
        check("resp_stable", 64'(resp_bad), 64'd0);
        check("busy_not_ready", 64'(busy_bad), 64'd0);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        i_valid = 1'b0;
        check("back_idle", 64'({o_valid, o_ready, o_mem_en}), 64'b010);
        $display("txn %0d st=%0b op=%0b addr=0x%08h en_cycles=%0d rdata=0x%08h mis=%0b",
                 idx, v.st, v.op, v.addr, en_cycles, cap_rdata, cap_mis);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_is_store = 1'b0; i_op = '0; i_addr = '0;
        i_wdata = '0; i_mem_rdata = '0; i_mem_ack = 1'b0; i_ready = 1'b0;

        //          st    op      addr          wdata         rdata        ack rdy en    e_addr        e_we     e_wdata       e_rdata       mis
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h5787_C949, 1, 0, 1'b1, 32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_FFC9, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8E87_0E49, 1, 1, 1'b1, 32'h0000_0100, 4'b0000, 32'h0, 32'h0000_8E87, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8E87_0E49, 2, 0, 1'b1, 32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_8E87, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_0006, 32'h0000_ABCD, 32'h0, 1, 0, 1'b1, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0});
`ifdef LS_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0002, 32'h0, 32'h1234_5678, 1, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h0000_F00D, 1, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1});
`else
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0002, 32'h0, 32'h1234_5678, 1, 0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h0000_F00D, 1, 0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0, 32'hFFFF_F00D, 1'b0});
`endif
        vecs.push_back('{1'b0, 3'b100, 32'h0000_0003, 32'h0, 32'h80FF_0000, 1, 0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0, 32'h0000_0080, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 1, 0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0, 32'h0000_007F, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h0000_0203, 32'hFFFF_FF5A, 32'h0, 1, 0, 1'b1, 32'h0000_0200, 4'b1000, 32'h5A5A_5A5A, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'b011, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 2, 0, 1'b1, 32'h0000_0008, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h0, 1, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'b110, 32'h0000_0010, 32'h0, 32'h0, 1, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'b110, 32'h0000_0010, 32'h1111_2222, 32'h0, 1, 2, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'b101, 32'h0000_0002, 32'h0000_1234, 32'h0, 1, 0, 1'b1, 32'h0000_0000, 4'b1100, 32'h1234_1234, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0104, 32'h0, 32'h89AB_CDEF, 1, 0, 1'b1, 32'h0000_0104, 4'b0000, 32'h0, 32'h89AB_CDEF, 1'b0});
        // long memory latency plus consumer back-pressure
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 4, 3, 1'b1, 32'h0000_0100, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0});

        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset_hold");
        i_rst = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("post_reset");

        // ack while idle must not create a response
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        check("idle_ack_valid", 64'(o_valid), 64'd0);
        check("idle_ack_ready", 64'(o_ready), 64'd1);
        $display("txn idle_ack done");

        // reset mid-ACCESS, then a late ack
        i_is_store = 1'b0; i_op = 3'b011; i_addr = 32'h0000_0040; i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("abort_in_access", 64'(o_mem_en), 64'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_outputs("abort_reset");
        i_mem_ack = 1'b1; i_mem_rdata = 32'hA5A5_A5A5;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        begin
            logic saw_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (o_valid) saw_valid = 1'b1;
                @(negedge i_clk);
            end
            check("abort_no_valid", 64'(saw_valid), 64'd0);
        end
        check_reset_outputs("abort_after_ack");
        $display("txn reset_abort done");

        foreach (vecs[i]) run_vec(i, vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
